// File: rtl/cam_frame_capture_if.sv
// Camera capture bus: pixel stream and capture request in; frozen 25x25 RGB444 frame, start and busy out.
interface cam_frame_capture_if;
    logic          capture;
    logic          pix_valid;
    logic          pix_sof;
    logic [11:0]   pix_data;
    logic [7499:0] out;
    logic          start;
    logic          busy;

    modport master (output capture, pix_valid, pix_sof, pix_data, input out, start, busy);
    modport slave  (input capture, pix_valid, pix_sof, pix_data, output out, start, busy);
endinterface

// File: rtl/cam_frame_capture.sv
// Decimating 25x25 frame grabber feeding the preprocess stage; frame is held frozen until the next capture.
// Optional: define CAM_CAPTURE_MIRROR_EN to mirror the stored frame horizontally.
module cam_frame_capture #(
    parameter int SRC_W  = 200,
    parameter int SRC_H  = 200,
    parameter int STEP   = 8,
    parameter int OFFSET = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    cam_frame_capture_if.slave bus
);
    localparam int GRID = 25;
    localparam int NPIX = GRID * GRID;
    localparam int XW   = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int YW   = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int SW   = (STEP > 1) ? $clog2(STEP) : 1;
    localparam int CW   = 5;
    localparam int AW   = 10;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [XW-1:0] X_LAST = XW'(SRC_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SRC_H - 1);
    localparam logic [SW-1:0] S_LAST = SW'(STEP - 1);
    localparam logic [SW-1:0] S_OFF  = SW'(OFFSET);
    localparam logic [CW-1:0] G_LAST = CW'(GRID - 1);
    localparam logic [CW-1:0] G_END  = CW'(GRID);

    logic [1:0]    state_q, state_n;
    logic [XW-1:0] x_q, x_n, cur_x;
    logic [YW-1:0] y_q, y_n, cur_y;
    logic [SW-1:0] sx_q, sx_n, cur_sx;
    logic [SW-1:0] sy_q, sy_n, cur_sy;
    logic [CW-1:0] col_q, col_n, cur_col;
    logic [CW-1:0] row_q, row_n, cur_row;
    logic [CW-1:0] wr_col;
    logic [AW-1:0] wr_idx;
    logic          beat_go, take, done_beat;
    logic          start_q, busy_q;
    logic [NPIX-1:0][11:0] frame_q;

    // A valid sof beat is processed as source (0,0), whatever the counters held.
    assign cur_x   = bus.pix_sof ? '0 : x_q;
    assign cur_y   = bus.pix_sof ? '0 : y_q;
    assign cur_sx  = bus.pix_sof ? '0 : sx_q;
    assign cur_sy  = bus.pix_sof ? '0 : sy_q;
    assign cur_col = bus.pix_sof ? '0 : col_q;
    assign cur_row = bus.pix_sof ? '0 : row_q;

    assign beat_go = bus.pix_valid &&
                     ((state_q == S_ARMED && bus.pix_sof) || state_q == S_CAPTURE);

    // col/row saturate at 25, which doubles as the x,y < 25*STEP window test.
    assign take = beat_go && (cur_sx == S_OFF) && (cur_sy == S_OFF) &&
                  (cur_col < G_END) && (cur_row < G_END);
    assign done_beat = take && (cur_col == G_LAST) && (cur_row == G_LAST);

`ifdef CAM_CAPTURE_MIRROR_EN
    assign wr_col = G_LAST - cur_col;
`else
    assign wr_col = cur_col;
`endif
    assign wr_idx = AW'(cur_row) * AW'(GRID) + AW'(wr_col);

    always_comb begin
        x_n   = cur_x + XW'(1);
        sx_n  = (cur_sx == S_LAST) ? '0 : cur_sx + SW'(1);
        col_n = (cur_sx == S_LAST && cur_col != G_END) ? cur_col + CW'(1) : cur_col;
        y_n   = cur_y;
        sy_n  = cur_sy;
        row_n = cur_row;
        if (cur_x == X_LAST) begin
            x_n   = '0;
            sx_n  = '0;
            col_n = '0;
            // y parks on the last line; trailing beats then never match a new row.
            if (cur_y != Y_LAST) begin
                y_n   = cur_y + YW'(1);
                sy_n  = (cur_sy == S_LAST) ? '0 : cur_sy + SW'(1);
                row_n = (cur_sy == S_LAST && cur_row != G_END) ? cur_row + CW'(1) : cur_row;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (bus.capture) state_n = S_ARMED;
            S_ARMED:        if (bus.pix_valid && bus.pix_sof) state_n = S_CAPTURE;
            S_CAPTURE:      state_n = S_CAPTURE;
            default:        state_n = S_IDLE;
        endcase
        if (done_beat) state_n = S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            start_q <= done_beat;
            busy_q  <= (state_n == S_ARMED) || (state_n == S_CAPTURE);
            if (beat_go) begin
                x_q   <= x_n;
                y_q   <= y_n;
                sx_q  <= sx_n;
                sy_q  <= sy_n;
                col_q <= col_n;
                row_q <= row_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_q <= '0;
        else if (take) frame_q[wr_idx] <= bus.pix_data;
    end

    assign bus.out   = frame_q;
    assign bus.start = start_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed/random bench for cam_frame_capture: two instances (default geometry and a small one) vs a frame-level model.
module tb_cam_frame_capture;
    localparam int A_W = 200, A_H = 200, A_S = 8, A_O = 4;
    localparam int B_W = 54,  B_H = 54,  B_S = 2, B_O = 1;
    localparam int NPIX = 625;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cam_frame_capture_if if_a();
    cam_frame_capture_if if_b();

    cam_frame_capture #(.SRC_W(A_W), .SRC_H(A_H), .STEP(A_S), .OFFSET(A_O))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    cam_frame_capture #(.SRC_W(B_W), .SRC_H(B_H), .STEP(B_S), .OFFSET(B_O))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    int sel;
    int mw, mh, ms, mo;
    int m_state;            // 0 idle, 1 armed, 2 capture, 3 done
    int mx, my;
    logic [7499:0] m_out;
    logic m_start, m_busy;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, beats = 0, start_seen = 0, start_beat = -1, start_cyc = -1, base_cyc = 0;
    logic obs_start, obs_busy;
    logic [7499:0] obs_out, snap_pat, all_fff, zero_frame;

    task automatic use_dut(input int s);
        sel = s;
        if (s == 0) begin mw = A_W; mh = A_H; ms = A_S; mo = A_O; end
        else begin mw = B_W; mh = B_H; ms = B_S; mo = B_O; end
    endtask

    task automatic model_reset();
        m_state = 0; mx = 0; my = 0; m_out = '0; m_start = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_beat(input logic [11:0] d);
        int c, r, col;
        if (mx % ms == mo && my % ms == mo && mx < 25 * ms && my < 25 * ms) begin
            c = mx / ms;
            r = my / ms;
`ifdef CAM_CAPTURE_MIRROR_EN
            col = 24 - c;
`else
            col = c;
`endif
            m_out[(r * 25 + col) * 12 +: 12] = d;
            if (r == 24 && c == 24) begin m_state = 3; m_start = 1'b1; end
        end
        if (mx == mw - 1) begin
            mx = 0;
            if (my < mh - 1) my++;
        end else mx++;
    endtask

    task automatic model_step(input logic cap, input logic v, input logic sof, input logic [11:0] d);
        m_start = 1'b0;
        case (m_state)
            0, 3: if (cap) m_state = 1;
            1: if (v && sof) begin m_state = 2; mx = 0; my = 0; model_beat(d); end
            2: if (v) begin
                   if (sof) begin mx = 0; my = 0; end
                   model_beat(d);
               end
            default: ;
        endcase
        m_busy = (m_state == 1 || m_state == 2);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7499:0] got, input logic [7499:0] exp);
        int p;
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            p = 0;
            for (int i = NPIX - 1; i >= 0; i--)
                if (got[i * 12 +: 12] !== exp[i * 12 +: 12]) p = i;
            $error("FAIL %s: pixel %0d got %03h want %03h", tag, p, got[p * 12 +: 12], exp[p * 12 +: 12]);
        end
    endtask

    task automatic sample();
        obs_start = (sel == 0) ? if_a.start : if_b.start;
        obs_busy  = (sel == 0) ? if_a.busy  : if_b.busy;
        obs_out   = (sel == 0) ? if_a.out   : if_b.out;
    endtask

    task automatic tick(input logic cap, input logic v, input logic sof, input logic [11:0] d);
        if (sel == 0) begin
            if_a.capture = cap; if_a.pix_valid = v; if_a.pix_sof = sof; if_a.pix_data = d;
            if_b.capture = 1'b0; if_b.pix_valid = 1'b0; if_b.pix_sof = 1'b0; if_b.pix_data = '0;
        end else begin
            if_b.capture = cap; if_b.pix_valid = v; if_b.pix_sof = sof; if_b.pix_data = d;
            if_a.capture = 1'b0; if_a.pix_valid = 1'b0; if_a.pix_sof = 1'b0; if_a.pix_data = '0;
        end
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(cap, v, sof, d);
        cyc++;
        if (v) beats++;
        #1;
        sample();
        chk("start", 32'(obs_start), 32'(m_start));
        chk("busy", 32'(obs_busy), 32'(m_busy));
        chk_out("out", obs_out, m_out);
        if (obs_start === 1'b1) begin start_seen++; start_beat = beats; start_cyc = cyc; end
    endtask

    // gap: 0 continuous, 1 alternate valid, 2 random idles; dmode: 0 coordinate pattern, 1 random, 2 all 12'hFFF
    task automatic send_frame(input int w, input int h, input int nbeats, input int gap,
                              input int dmode, input bit sof0, input bit rcap);
        logic [11:0] d;
        logic [3:0] xl, yl;
        int x, y;
        for (int i = 0; i < nbeats && i < w * h; i++) begin
            x = i % w;
            y = i / w;
            if (gap == 2)
                while ($urandom_range(0, 3) == 0)
                    tick(rcap && ($urandom_range(0, 15) == 0), 1'b0, 1'($urandom_range(0, 1)), 12'($urandom));
            xl = x[3:0];
            yl = y[3:0];
            case (dmode)
                0: d = {yl, xl, 4'hA};
                1: d = 12'($urandom);
                default: d = 12'hFFF;
            endcase
            tick(1'b0, 1'b1, sof0 && (i == 0), d);
            if (gap == 1) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 12'($urandom));
        end
    endtask

    task automatic phase_start();
        start_seen = 0; start_beat = -1; start_cyc = -1; beats = 0; base_cyc = cyc;
    endtask

    initial begin
        if_a.capture = 1'b0; if_a.pix_valid = 1'b0; if_a.pix_sof = 1'b0; if_a.pix_data = '0;
        if_b.capture = 1'b0; if_b.pix_valid = 1'b0; if_b.pix_sof = 1'b0; if_b.pix_data = '0;
        zero_frame = '0;
        all_fff = {NPIX{12'hFFF}};
        use_dut(0);
        model_reset();

        // reset state, then beats without capture are ignored
        repeat (3) tick(1'b0, 1'b1, 1'b1, 12'hFFF);
        chk("rst_start", 32'(obs_start), 32'd0);
        chk("rst_busy", 32'(obs_busy), 32'd0);
        chk_out("rst_out", obs_out, zero_frame);
        rst_n = 1'b1;
        phase_start();
        send_frame(A_W, A_H, 300, 0, 1, 1'b1, 1'b0);
        chk_out("nocap_out", obs_out, zero_frame);
        chk("nocap_starts", start_seen, 0);

        // default-geometry full capture
        tick(1'b1, 1'b0, 1'b0, 12'h000);
        phase_start();
        send_frame(A_W, A_H, 196 * 200 + 197 + 3, 0, 0, 1'b1, 1'b0);
        chk("A_start_count", start_seen, 1);
        chk("A_start_beat", start_beat, 196 * 200 + 197);
        chk("A_px0", 32'(obs_out[0 +: 12]), 32'h44A);
        chk("A_px24", 32'(obs_out[24 * 12 +: 12]), 32'h44A);
        chk("A_px624", 32'(obs_out[624 * 12 +: 12]), 32'h44A);
        chk("A_busy_done", 32'(obs_busy), 32'd0);

        // small geometry from here on; it has only seen reset so far
        use_dut(1);
        model_reset();
        tick(1'b0, 1'b0, 1'b0, 12'h000);
        chk_out("B_rst_out", obs_out, zero_frame);

        tick(1'b1, 1'b0, 1'b0, 12'h000);
        chk("B_busy_armed", 32'(obs_busy), 32'd1);
        phase_start();
        send_frame(B_W, B_H, B_W * B_H, 0, 0, 1'b1, 1'b0);
        snap_pat = m_out;
        chk("B_start_count", start_seen, 1);
        chk("B_start_beat", start_beat, 49 * 54 + 50);

        // frozen: a new frame without capture leaves out alone
        phase_start();
        send_frame(B_W, B_H, B_W * B_H, 0, 1, 1'b1, 1'b0);
        chk_out("freeze_out", obs_out, snap_pat);
        chk("freeze_starts", start_seen, 0);

        // sof mid-frame restarts with all-FFF data
        tick(1'b1, 1'b0, 1'b0, 12'h000);
        phase_start();
        send_frame(B_W, B_H, 20 * B_W, 0, 0, 1'b1, 1'b0);
        chk("midsof_no_early_start", start_seen, 0);
        beats = 0;
        send_frame(B_W, B_H, B_W * B_H, 0, 2, 1'b1, 1'b0);
        chk("midsof_start_count", start_seen, 1);
        chk("midsof_start_beat", start_beat, 49 * 54 + 50);
        chk_out("midsof_all_fff", obs_out, all_fff);

        // alternating valid gives the continuous result, start twice as late
        tick(1'b1, 1'b0, 1'b0, 12'h000);
        phase_start();
        send_frame(B_W, B_H, B_W * B_H, 1, 0, 1'b1, 1'b0);
        chk_out("gapped_out", obs_out, snap_pat);
        chk("gapped_start_count", start_seen, 1);
        chk("gapped_start_cyc", start_cyc - base_cyc, 2 * (49 * 54 + 50) - 1);

        // capture with a same-cycle sof only arms; following beats are not stored
        phase_start();
        tick(1'b1, 1'b1, 1'b1, 12'($urandom));
        send_frame(B_W, B_H, 2 * B_W, 0, 1, 1'b0, 1'b0);
        chk_out("capsof_out", obs_out, snap_pat);
        chk("capsof_busy", 32'(obs_busy), 32'd1);
        send_frame(B_W, B_H, B_W * B_H, 2, 1, 1'b1, 1'b1);
        chk("rand_start_count", start_seen, 1);

        // reset mid-frame returns to idle and clears the buffer
        tick(1'b1, 1'b0, 1'b0, 12'h000);
        phase_start();
        send_frame(B_W, B_H, 1500, 0, 1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        sample();
        chk("midrst_busy", 32'(obs_busy), 32'd0);
        chk_out("midrst_out", obs_out, zero_frame);
        tick(1'b0, 1'b0, 1'b0, 12'h000);
        rst_n = 1'b1;
        send_frame(B_W, B_H, B_W * B_H, 0, 1, 1'b1, 1'b0);
        chk("postrst_starts", start_seen, 0);
        chk_out("postrst_out", obs_out, zero_frame);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
